ex_mul_unit: RTL
================

// Module: ex_mul_unit
// PURPOSE
//  Iterative multi-cycle multiplier for the RV32M MUL/MULH/MULHSU/MULHU group, located in the EX stage.
//  Consumes the 4-bit ALUOp that decode drives for funct7=0000001 R-type instructions, plus the forwarded rs1/rs2 values.
//  Holds the pipeline through stall_o until the product is ready, then presents a one-cycle result to EX/MEM.
// PARAMETERS
//  XLEN        32  operand/result width
//  RADIX_BITS  1   multiplier bits consumed per CALC cycle; legal values 1, 2, 4; XLEN % RADIX_BITS == 0
// PORTS
//  clk       in   1     clock; all state updates on rising edge
//  rst       in   1     synchronous, active-high reset
//  start_i   in   1     EX holds a valid M-op this cycle
//  op_i      in   4     ALUOp; only `MUL_OP_MUL/MULH/MULHSU/MULHU are accepted
//  rs1_i     in   XLEN  multiplicand (post-forwarding)
//  rs2_i     in   XLEN  multiplier (post-forwarding)
//  flush_i   in   1     kill in-flight op (branch mispredict / trap)
//  busy_o    out  1     FSM not in IDLE
//  stall_o   out  1     freeze IF/ID/EX (combinational)
//  valid_o   out  1     result_o valid this cycle (1-cycle pulse)
//  result_o  out  XLEN  selected half of product
// BEHAVIOUR
//  Reset: state=IDLE; busy_o=0, valid_o=0, result_o=0; all internal registers cleared.
//  Reset dominates flush_i and start_i, including mid-operation.
//  States and transitions:
//   - IDLE: start_i & op_i is a MUL op & !flush_i -> CALC. On entry:
//       latch |rs1|, |rs2|, op, and neg = sign(rs1)^sign(rs2) (signedness per op);
//       clear the 2*XLEN accumulator; load cnt = XLEN/RADIX_BITS-1.
//   - CALC: each cycle add (mcand * low RADIX_BITS of mplier), shifted, into the accumulator;
//       shift mplier right by RADIX_BITS; cnt--. When cnt==0 -> DONE.
//   - DONE: valid_o=1; result_o = op==MUL ? low XLEN of signed product : high XLEN. -> IDLE next cycle.
//  Signedness: MUL/MULH treat rs1 and rs2 as signed; MULHSU treats rs1 signed, rs2 unsigned; MULHU treats both unsigned.
//   - Magnitudes are held in XLEN unsigned bits: |-2^31| = 0x80000000, no overflow.
//   - Final product = neg ? (~acc + 1) : acc, at 2*XLEN width. MUL low half is sign-independent.
//  Latency: start sampled at edge N; valid_o asserted in cycle N + XLEN/RADIX_BITS + 1 (33 at defaults).
//  result_o is registered and holds its value after DONE until the next DONE or reset.
//  stall_o = (state==CALC) | (state==IDLE & start_i & is_mul_op & !flush_i). Deasserted in DONE, so EX/MEM captures result_o on that edge.
//  busy_o = (state != IDLE).
//  start_i with a non-MUL op_i: ignored; no stall.
//  start_i while busy: ignored. The pipeline is stalled, so the same instruction is still held and is not re-issued.
//  flush_i in CALC or DONE: next state IDLE, valid_o forced 0 that cycle, result_o unchanged.
//  flush_i in IDLE alongside start_i: op not accepted.
//  Next start may be accepted in the cycle immediately after DONE (back-to-back M-ops).
// STRUCTURE
//  Shared package (defines.v): `MUL_OP_MUL/MULH/MULHSU/MULHU codes (existing); add `MUL_LATENCY = XLEN/RADIX_BITS+1
//  and the state encodings `MUL_ST_IDLE/CALC/DONE.
//  One sub-module, mul_sign_ctl: combinational block giving operand magnitudes and the neg flag from op plus operand MSBs.
//  The FSM and shift-add datapath stay in ex_mul_unit.
// TESTING
//  1. MUL 3 x 5 -> busy_o high 33 cycles; valid_o pulse at N+33 with result_o=0x0000000F.
//  2. MUL 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFE. MULH with the same operands -> 0xFFFFFFFF.
//  3. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with the same operands -> 0xFFFFFFFF.
//  4. MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL with the same operands -> 0x00000000.
//  5. Flush and reset:
//     - flush_i at CALC cycle 10 -> IDLE next cycle; no valid_o; result_o unchanged; new start accepted next cycle.
//     - rst at CALC cycle 5 -> all outputs 0 the following cycle.
//  6. Ignored starts and back-to-back ops:
//     - start_i with op_i=`ALU_OP_ADD -> no stall, no valid.
//     - Second start while busy -> ignored.
//     - Back-to-back MUL 7x6 then 2x2 -> 42, then 4, with no idle gap beyond one cycle.

Source files
------------

// File: rtl/ex_mul_unit_pkg.sv
// ex_mul_unit_pkg
//   Shared definitions for the EX-stage iterative multiplier:
//   - default operand width and radix,
//   - the ALUOp codes decode produces,
//   - FSM state encodings,
//   - a helper that recognises the RV32M multiply group.
package ex_mul_unit_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_RADIX_BITS = 1;
  localparam int MUL_LATENCY    = DEF_XLEN / DEF_RADIX_BITS + 1;

  // ALUOp codes driven by decode; only the MUL_OP_* group reaches the multiplier FSM
  localparam logic [3:0] ALU_OP_ADD    = 4'h0;
  localparam logic [3:0] ALU_OP_SUB    = 4'h1;
  localparam logic [3:0] ALU_OP_AND    = 4'h2;
  localparam logic [3:0] ALU_OP_OR     = 4'h3;
  localparam logic [3:0] MUL_OP_MUL    = 4'hA;
  localparam logic [3:0] MUL_OP_MULH   = 4'hB;
  localparam logic [3:0] MUL_OP_MULHSU = 4'hC;
  localparam logic [3:0] MUL_OP_MULHU  = 4'hD;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_CALC = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MUL_OP_MUL)    || (op == MUL_OP_MULH) ||
           (op == MUL_OP_MULHSU) || (op == MUL_OP_MULHU);
  endfunction

endpackage

// File: rtl/ex_mul_unit_if.sv
// ex_mul_unit_if
//   Request/response bundle between the EX stage and the multiplier.
//   master : EX-stage side (drives start/op/operands/flush)
//   slave  : multiplier side (drives busy/stall/valid/result)
//   Signals:
//     start_i  - EX holds a valid M-op this cycle
//     op_i     - 4-bit ALUOp
//     rs1_i    - multiplicand after forwarding
//     rs2_i    - multiplier after forwarding
//     flush_i  - kill the in-flight op
//     busy_o   - multiplier not idle
//     stall_o  - freeze IF/ID/EX
//     valid_o  - result_o valid this cycle
//     result_o - selected product half
interface ex_mul_unit_if
  import ex_mul_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);

  logic            start_i;
  logic [3:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, stall_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, stall_o, valid_o, result_o
  );

endinterface

// File: rtl/ex_mul_unit_sign_ctl.sv
// ex_mul_unit_sign_ctl
//   Combinational sign handling for the multiplier. Converts both operands
//   to unsigned magnitudes and reports whether the final product must be
//   negated, according to the signedness of the selected op.
//   Ports:
//     op   in  4     ALUOp (one of the MUL group)
//     rs1  in  XLEN  multiplicand
//     rs2  in  XLEN  multiplier
//     mag1 out XLEN  |rs1| under the op's signedness
//     mag2 out XLEN  |rs2| under the op's signedness
//     neg  out 1     product sign
module ex_mul_unit_sign_ctl
  import ex_mul_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            neg
);

  logic rs1_signed;
  logic rs2_signed;
  logic rs1_neg;
  logic rs2_neg;

  // rs1 is signed for every op except MULHU; rs2 only for MUL/MULH.
  // The magnitude of the most negative value fits unsigned XLEN bits.
  always_comb begin
    rs1_signed = (op != MUL_OP_MULHU);
    rs2_signed = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    rs1_neg    = rs1_signed & rs1[XLEN-1];
    rs2_neg    = rs2_signed & rs2[XLEN-1];
    mag1       = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
    mag2       = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;
    neg        = rs1_neg ^ rs2_neg;
  end

endmodule

// File: rtl/ex_mul_unit.sv
// ex_mul_unit
//   Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU in the EX stage.
//   Accepts an op from IDLE, spends XLEN/RADIX_BITS CALC cycles accumulating
//   partial products of the operand magnitudes, then presents the selected
//   product half for one DONE cycle while releasing the pipeline stall.
//   Ports:
//     clk  in  1  clock, rising edge
//     rst  in  1  synchronous active-high reset
//     bus  slave modport of ex_mul_unit_if (start/op/rs1/rs2/flush in,
//          busy/stall/valid/result out)
module ex_mul_unit
  import ex_mul_unit_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int RADIX_BITS = DEF_RADIX_BITS
) (
  input  logic            clk,
  input  logic            rst,
  ex_mul_unit_if.slave    bus
);

  localparam int STEPS = XLEN / RADIX_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  mul_state_t          state_q;
  mul_state_t          state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          op_q;
  logic                neg_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [XLEN-1:0]     result_q;

  logic [XLEN-1:0]     mag1;
  logic [XLEN-1:0]     mag2;
  logic                neg_in;
  logic                accept;
  logic                load;
  logic                step;
  logic                commit;
  logic                stall;
  logic                busy;
  logic                valid;
  logic [2*XLEN-1:0]   partial;
  logic [2*XLEN-1:0]   product;
  logic [XLEN-1:0]     result_sel;

  ex_mul_unit_sign_ctl #(
    .XLEN (XLEN)
  ) u_sign_ctl (
    .op   (bus.op_i),
    .rs1  (bus.rs1_i),
    .rs2  (bus.rs2_i),
    .mag1 (mag1),
    .mag2 (mag2),
    .neg  (neg_in)
  );

  // A new op is only taken when it is a multiply and is not being killed
  assign accept = bus.start_i & is_mul_op(bus.op_i) & ~bus.flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode. Stall covers the accepting IDLE cycle
  // and all of CALC; DONE drops it so EX/MEM captures the result on that edge.
  // Starts seen outside IDLE are ignored because the stalled pipeline keeps
  // presenting the same instruction.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    busy    = 1'b0;
    valid   = 1'b0;
    case (state_q)
      MUL_ST_IDLE: begin
        if (accept) begin
          state_d = MUL_ST_CALC;
          load    = 1'b1;
          stall   = 1'b1;
        end
      end
      MUL_ST_CALC: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (bus.flush_i) begin
          state_d = MUL_ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            state_d = MUL_ST_DONE;
          end
        end
      end
      MUL_ST_DONE: begin
        busy    = 1'b1;
        state_d = MUL_ST_IDLE;
        if (!bus.flush_i) begin
          valid  = 1'b1;
          commit = 1'b1;
        end
      end
      default: begin
        state_d = MUL_ST_IDLE;
      end
    endcase
  end

  // Partial product for this step: the shifted multiplicand added once for
  // every set bit in the low RADIX_BITS of the multiplier.
  always_comb begin
    partial = '0;
    for (int b = 0; b < RADIX_BITS; b++) begin
      if (mplier_q[b]) begin
        partial = partial + (mcand_q << b);
      end
    end
  end

  // Reapply the sign to the magnitude product, then pick the requested half
  always_comb begin
    product    = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    result_sel = (op_q == MUL_OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // Operand latch and shift-add datapath. The multiplicand is kept at
  // double width and shifted left each step so the accumulator never shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      if (load) begin
        op_q     <= bus.op_i;
        neg_q    <= neg_in;
        acc_q    <= '0;
        mcand_q  <= {{XLEN{1'b0}}, mag1};
        mplier_q <= mag2;
        cnt_q    <= CNT_W'(STEPS - 1);
      end else if (step) begin
        acc_q    <= acc_q + partial;
        mcand_q  <= mcand_q << RADIX_BITS;
        mplier_q <= mplier_q >> RADIX_BITS;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        result_q <= result_sel;
      end
    end
  end

  // During a committing DONE cycle the fresh product is shown; otherwise the
  // last committed value is held, so a flushed DONE leaves result_o unchanged.
  assign bus.result_o = commit ? result_sel : result_q;
  assign bus.valid_o  = valid;
  assign bus.stall_o  = stall;
  assign bus.busy_o   = busy;

endmodule
